ir_key_tracker: RTL and testbench



---
 rtl/ir_key_pkg.sv | 20 ++
 rtl/ms_tick_gen.sv | 38 +++
 rtl/ir_key_tracker.sv | 179 +++++++++++++++++
 tb/tb_ir_key_tracker.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_key_pkg.sv
// Shared constants for the IR key tracker: state encoding, widths and default timing.
package ir_key_pkg;

    localparam int unsigned CODE_W = 12;
    localparam int unsigned MS_W   = 16;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ST_W   = 2;

    localparam logic [ST_W-1:0] S_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] S_CONFIRM = 2'd1;
    localparam logic [ST_W-1:0] S_HELD    = 2'd2;
    localparam logic [ST_W-1:0] S_PEND    = 2'd3;

    localparam int unsigned DEF_CLK_HZ    = 50_000_000;
    localparam int unsigned DEF_CONFIRM   = 2;
    localparam int unsigned DEF_GAP_MS    = 60;
    localparam int unsigned DEF_HOLD_MS   = 500;
    localparam int unsigned DEF_REPEAT_MS = 200;

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler; tick is a one-cycle pulse every CLK_HZ/1000 cycles.
module ms_tick_gen
    import ir_key_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV  = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Wrap the divider at LAST and flag the wrap cycle.
    always_comb begin
        tick_d = (cnt_q == LAST);
        cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end

    // Prescaler state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/ir_key_tracker.sv
// Turns the stream of decoded IR frames into press / auto-repeat / release key events.
module ir_key_tracker
    import ir_key_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter int unsigned CONFIRM   = DEF_CONFIRM,
    parameter int unsigned GAP_MS    = DEF_GAP_MS,
    parameter int unsigned HOLD_MS   = DEF_HOLD_MS,
    parameter int unsigned REPEAT_MS = DEF_REPEAT_MS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] data,
    input  logic              data_rdy,
    output logic [CODE_W-1:0] cmd,
    output logic              press,
    output logic              rpt,
    output logic              key_release,
    output logic              held
);

    localparam logic [MS_W-1:0]  GAP_LIM  = MS_W'(GAP_MS);
    localparam logic [MS_W-1:0]  HOLD_LIM = MS_W'(HOLD_MS);
    localparam logic [MS_W-1:0]  REP_LIM  = MS_W'(REPEAT_MS);
    localparam logic [CNT_W-1:0] CONF_LIM = CNT_W'(CONFIRM);
    localparam bit               SINGLE   = (CONFIRM == 1);
    localparam bit               REP_EN   = (REPEAT_MS != 0);

    logic [ST_W-1:0]   state_q, state_d;
    logic              rdy_q;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MS_W-1:0]   gap_q, gap_d;
    logic [MS_W-1:0]   hold_q, hold_d;
    logic [MS_W-1:0]   lim_q, lim_d;
    logic [CODE_W-1:0] cmd_q, cmd_d;
    logic              press_q, press_d;
    logic              rpt_q, rpt_d;
    logic              rel_q, rel_d;
    logic              held_q, held_d;

    logic              tick;
    logic              frame;
    logic              gap_hit;
    logic              hold_hit;
    logic [CNT_W-1:0]  cnt_inc;
    logic [MS_W:0]     hold_inc;

    ms_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Rising edge of data_rdy is one frame; the timers expire on the tick that reaches the limit.
    assign frame    = data_rdy & ~rdy_q;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign gap_hit  = tick & (gap_q != GAP_LIM) & ((gap_q + MS_W'(1)) == GAP_LIM);
    assign hold_inc = {1'b0, hold_q} + (MS_W + 1)'(1);
    assign hold_hit = tick & (hold_inc >= {1'b0, lim_q});

    // Next-state decode; a frame always takes priority over gap expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (frame) state_d = SINGLE ? S_HELD : S_CONFIRM;
            end
            S_CONFIRM: begin
                if (frame) begin
                    if ((data == cand_q) && (cnt_inc == CONF_LIM)) state_d = S_HELD;
                end else if (gap_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_HELD: begin
                if (frame) begin
                    if (data != cmd_q) state_d = SINGLE ? S_PEND : S_CONFIRM;
                end else if (gap_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_PEND: begin
                state_d = S_HELD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Candidate tracking, timers and the registered event outputs derived from the transition.
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        lim_d   = lim_q;
        cmd_d   = cmd_q;
        press_d = 1'b0;
        rpt_d   = 1'b0;
        rel_d   = 1'b0;
        held_d  = (state_d == S_HELD);

        if (frame) begin
            gap_d = '0;
        end else if (tick && (gap_q != GAP_LIM)) begin
            gap_d = gap_q + MS_W'(1);
        end

        if (frame) begin
            if ((state_q == S_CONFIRM) && (data == cand_q)) begin
                cnt_d = cnt_inc;
            end else if ((state_q != S_HELD) || (data != cmd_q)) begin
                cand_d = data;
                cnt_d  = CNT_W'(1);
            end
        end

        if (tick && (state_q == S_HELD)) begin
            if (hold_hit) begin
                hold_d = '0;
                lim_d  = REP_LIM;
            end else if (hold_q != '1) begin
                hold_d = hold_q + MS_W'(1);
            end
        end

        press_d = (state_d == S_HELD) && (state_q != S_HELD);
        rel_d   = (state_q == S_HELD) && (state_d != S_HELD);
        rpt_d   = REP_EN && (state_q == S_HELD) && (state_d == S_HELD) && hold_hit;

        if (press_d) begin
            cmd_d  = (state_q == S_PEND) ? cand_q : data;
            hold_d = '0;
            lim_d  = HOLD_LIM;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            cand_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            hold_q  <= '0;
            lim_q   <= '0;
            cmd_q   <= '0;
            press_q <= 1'b0;
            rpt_q   <= 1'b0;
            rel_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= data_rdy;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
            lim_q   <= lim_d;
            cmd_q   <= cmd_d;
            press_q <= press_d;
            rpt_q   <= rpt_d;
            rel_q   <= rel_d;
            held_q  <= held_d;
        end
    end

    assign cmd         = cmd_q;
    assign press       = press_q;
    assign rpt         = rpt_q;
    assign key_release = rel_q;
    assign held        = held_q;

endmodule

// File: tb/tb_ir_key_tracker.sv
// Bench for ir_key_tracker: directed scenarios plus randomized frame trains checked
// against an event-level model computed from the frame schedule.
module tb_ir_key_tracker;

    localparam int CLK_HZ    = 1000;
    localparam int CONFIRM   = 2;
    localparam int GAP_MS    = 60;
    localparam int HOLD_MS   = 500;
    localparam int REPEAT_MS = 200;
    localparam int NEVER     = 2147483647;

    logic        clk;
    logic        rst;
    logic        data_rdy;
    logic [11:0] data;
    logic [11:0] cmd;
    logic        press;
    logic        rpt;
    logic        key_release;
    logic        held;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int base   = 0;

    int          ft[$];
    logic [11:0] fc[$];
    int          exp_p_t[$];
    logic [11:0] exp_p_c[$];
    int          exp_r_t[$];
    int          exp_l_t[$];
    logic [11:0] exp_l_c[$];
    int          obs_p_t[$];
    logic [11:0] obs_p_c[$];
    int          obs_r_t[$];
    int          obs_l_t[$];
    logic [11:0] obs_l_c[$];
    logic [2:0]  obs_v[$];
    logic        obs_h[$];

    ir_key_tracker #(
        .CLK_HZ    (CLK_HZ),
        .CONFIRM   (CONFIRM),
        .GAP_MS    (GAP_MS),
        .HOLD_MS   (HOLD_MS),
        .REPEAT_MS (REPEAT_MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .data_rdy    (data_rdy),
        .cmd         (cmd),
        .press       (press),
        .rpt         (rpt),
        .key_release (key_release),
        .held        (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse with the cycle it is visible in.
    always @(negedge clk) begin
        if (press) begin
            obs_p_t.push_back(cyc);
            obs_p_c.push_back(cmd);
        end
        if (rpt) obs_r_t.push_back(cyc);
        if (key_release) begin
            obs_l_t.push_back(cyc);
            obs_l_c.push_back(cmd);
        end
        if (press || rpt || key_release) begin
            obs_v.push_back({press, rpt, key_release});
            obs_h.push_back(held);
        end
    end

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic start();
        ft.delete(); fc.delete();
        obs_p_t.delete(); obs_p_c.delete(); obs_r_t.delete();
        obs_l_t.delete(); obs_l_c.delete(); obs_v.delete(); obs_h.delete();
        base = cyc;
    endtask

    task automatic at(input int off);
        while (cyc < base + off) tick1();
    endtask

    // One frame: data_rdy high for width cycles starting now.
    task automatic send(input logic [11:0] code, input int width);
        data     = code;
        data_rdy = 1'b1;
        ft.push_back(cyc);
        fc.push_back(code);
        repeat (width) tick1();
        data_rdy = 1'b0;
        data     = 12'($urandom);
    endtask

    // Repeats strictly before the release cycle, then the release itself.
    task automatic model_end(input int pt, input int rt, input logic [11:0] k, input int cut);
        int r;
        if (REPEAT_MS != 0) begin
            r = pt + HOLD_MS;
            while (r < rt) begin
                if (r <= cut) exp_r_t.push_back(r);
                r += REPEAT_MS;
            end
        end
        if (rt <= cut) begin
            exp_l_t.push_back(rt);
            exp_l_c.push_back(k);
        end
    endtask

    // Walks the frame list: frames more than GAP_MS apart break the session.
    task automatic model_run(input int cut);
        bit          hold;
        logic [11:0] k, cand;
        int          cnt, last, pt, lat;
        hold = 1'b0; k = '0; cand = '0; cnt = 0; last = 0; pt = 0;
        exp_p_t.delete(); exp_p_c.delete(); exp_r_t.delete();
        exp_l_t.delete(); exp_l_c.delete();
        for (int i = 0; i < ft.size(); i++) begin
            lat = 1;
            if (i > 0 && ft[i] - last > GAP_MS) begin
                if (hold) model_end(pt, last + GAP_MS + 1, k, cut);
                hold = 1'b0;
                cnt  = 0;
            end
            if (hold) begin
                if (fc[i] != k) begin
                    model_end(pt, ft[i] + 1, k, cut);
                    hold = 1'b0;
                    cand = fc[i];
                    cnt  = 1;
                    lat  = 2;
                end
            end else if (cnt > 0 && fc[i] == cand) begin
                cnt++;
            end else begin
                cand = fc[i];
                cnt  = 1;
            end
            if (!hold && cnt == CONFIRM) begin
                hold = 1'b1;
                k    = cand;
                pt   = ft[i] + lat;
                cnt  = 0;
                if (pt <= cut) begin
                    exp_p_t.push_back(pt);
                    exp_p_c.push_back(k);
                end
            end
            last = ft[i];
        end
        if (hold) model_end(pt, last + GAP_MS + 1, k, cut);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_press_n"}, obs_p_t.size(), exp_p_t.size());
        for (int i = 0; i < exp_p_t.size() && i < obs_p_t.size(); i++) begin
            chk($sformatf("%s_press_t%0d", tag, i), obs_p_t[i], exp_p_t[i]);
            chk($sformatf("%s_press_cmd%0d", tag, i), int'(obs_p_c[i]), int'(exp_p_c[i]));
        end
        chk({tag, "_rpt_n"}, obs_r_t.size(), exp_r_t.size());
        for (int i = 0; i < exp_r_t.size() && i < obs_r_t.size(); i++)
            chk($sformatf("%s_rpt_t%0d", tag, i), obs_r_t[i], exp_r_t[i]);
        chk({tag, "_rel_n"}, obs_l_t.size(), exp_l_t.size());
        for (int i = 0; i < exp_l_t.size() && i < obs_l_t.size(); i++) begin
            chk($sformatf("%s_rel_t%0d", tag, i), obs_l_t[i], exp_l_t[i]);
            chk($sformatf("%s_rel_cmd%0d", tag, i), int'(obs_l_c[i]), int'(exp_l_c[i]));
        end
        for (int i = 0; i < obs_v.size(); i++) begin
            chk($sformatf("%s_onehot%0d", tag, i), $countones(obs_v[i]), 1);
            chk($sformatf("%s_held_on_pulse%0d", tag, i), int'(obs_h[i]), int'(!obs_v[i][0]));
        end
    endtask

    task automatic finish_scn(input string tag, input int cut);
        repeat (GAP_MS + 20) tick1();
        model_run(cut);
        compare_all(tag);
    endtask

    task automatic rand_scn(input string tag, input int nframes);
        logic [11:0] codes [3];
        logic [11:0] c;
        int          sp, w, t0;
        codes = '{12'h095, 12'h012, 12'hABC};
        c = codes[$urandom_range(2)];
        start();
        for (int i = 0; i < nframes; i++) begin
            if ($urandom_range(9) == 0) c = codes[$urandom_range(2)];
            case ($urandom_range(9))
                0:       sp = 59;
                1:       sp = 60;
                2:       sp = 61;
                3:       sp = 62 + int'($urandom_range(40));
                default: sp = 20 + int'($urandom_range(38));
            endcase
            w  = 1 + int'($urandom_range(9));
            t0 = cyc;
            send(c, w);
            while (cyc < t0 + sp) tick1();
        end
        finish_scn(tag, NEVER);
    endtask

    initial begin
        rst      = 1'b1;
        data_rdy = 1'b0;
        data     = '0;
        repeat (3) tick1();
        chk("reset_cmd", int'(cmd), 0);
        chk("reset_press", int'(press), 0);
        chk("reset_rpt", int'(rpt), 0);
        chk("reset_release", int'(key_release), 0);
        chk("reset_held", int'(held), 0);
        rst = 1'b0;
        repeat (5) tick1();

        // Lone frame is dropped; a later pair presses normally.
        start();
        send(12'h095, 1);
        at(100); send(12'h095, 1);
        at(145); send(12'h095, 1);
        finish_scn("t1", NEVER);
        chk("t1_press_at", qat(obs_p_t, 0) - base, 146);
        chk("t1_release_at", qat(obs_l_t, 0) - base, 206);

        // Two frames -> press then gap release.
        start();
        send(12'h095, 1);
        at(45); send(12'h095, 1);
        finish_scn("t2", NEVER);
        chk("t2_press_at", qat(obs_p_t, 0) - base, 46);
        chk("t2_press_cmd", int'(obs_p_c.size() > 0 ? obs_p_c[0] : 12'h0), 12'h095);
        chk("t2_release_at", qat(obs_l_t, 0) - base, 106);

        // Long hold with auto-repeat.
        start();
        for (int k = 0; k <= 990; k += 45) begin
            at(k);
            send(12'h095, 1);
        end
        finish_scn("t3", NEVER);
        chk("t3_rpt0_at", qat(obs_r_t, 0) - base, 546);
        chk("t3_rpt1_at", qat(obs_r_t, 1) - base, 746);
        chk("t3_rpt2_at", qat(obs_r_t, 2) - base, 946);
        chk("t3_release_at", qat(obs_l_t, 0) - base, 1051);

        // Code change while held.
        start();
        send(12'h095, 1);
        at(45);  send(12'h095, 1);
        at(90);  send(12'h012, 1);
        at(135); send(12'h012, 1);
        finish_scn("t4", NEVER);
        chk("t4_release_at", qat(obs_l_t, 0) - base, 91);
        chk("t4_release_cmd", int'(obs_l_c.size() > 0 ? obs_l_c[0] : 12'h0), 12'h095);
        chk("t4_press2_at", qat(obs_p_t, 1) - base, 136);
        chk("t4_press2_cmd", int'(obs_p_c.size() > 1 ? obs_p_c[1] : 12'h0), 12'h012);

        // Long data_rdy level counts once.
        start();
        send(12'h3A5, 10);
        at(45); send(12'h3A5, 1);
        finish_scn("t5", NEVER);
        chk("t5_press_at", qat(obs_p_t, 0) - base, 46);

        // Gap boundary: 60 still joins, 61 starts over.
        start();
        send(12'h0A5, 1);
        at(60);  send(12'h0A5, 1);
        at(200); send(12'h5C5, 1);
        at(261); send(12'h5C5, 1);
        at(300); send(12'h5C5, 1);
        finish_scn("tgap", NEVER);
        chk("tgap_press0_at", qat(obs_p_t, 0) - base, 61);
        chk("tgap_press1_at", qat(obs_p_t, 1) - base, 301);

        // Reset while held: no release, clean restart.
        start();
        send(12'h095, 1);
        at(45); send(12'h095, 1);
        at(80);
        rst = 1'b1;
        tick1();
        chk("t6_cmd_after_rst", int'(cmd), 0);
        chk("t6_held_after_rst", int'(held), 0);
        chk("t6_release_after_rst", int'(key_release), 0);
        rst = 1'b0;
        finish_scn("t6_pre", base + 80);
        start();
        send(12'h3C3, 1);
        at(45); send(12'h3C3, 1);
        finish_scn("t6_post", NEVER);
        chk("t6_press_at", qat(obs_p_t, 0) - base, 46);

        // Randomized frame trains.
        rand_scn("rnd0", 40);
        rand_scn("rnd1", 40);
        rand_scn("rnd2", 40);
        rand_scn("rnd3", 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
